// File: rtl/weight_loader_pkg.sv
// Weight loader shared definitions.
// Bank geometry is also used by the weight read path.
package weight_loader_pkg;

  localparam int NUM_BANKS      = 16;
  localparam int CONV1_BANKS    = 6;
  localparam int KERNEL_ENTRIES = 25;
  localparam int CONV2_BASE     = 25;

  localparam int BANK_W  = 4;
  localparam int ENTRY_W = 5;
  localparam int ADDR_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } wl_state_e;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(
    input logic [BANK_W-1:0] b
  );
    return NUM_BANKS'(1) << b;
  endfunction

endpackage

// File: rtl/weight_loader.sv
// Streams conv-layer weight bytes into per-bank BRAMs,
// entry-major, one byte per valid/ready handshake.
module weight_loader
  import weight_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        nth_conv_i,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [15:0] wr_en,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        load_done
);

  localparam logic [BANK_W-1:0]  L1_LAST =
    BANK_W'(CONV1_BANKS - 1);
  localparam logic [BANK_W-1:0]  L2_LAST =
    BANK_W'(NUM_BANKS - 1);
  localparam logic [ENTRY_W-1:0] E_LAST  =
    ENTRY_W'(KERNEL_ENTRIES - 1);
  localparam logic [ADDR_W-1:0]  BASE2   =
    ADDR_W'(CONV2_BASE);

  wl_state_e           state;
  logic                layer;
  logic [BANK_W-1:0]   bank_cnt;
  logic [ENTRY_W-1:0]  entry_cnt;

  logic                hs;
  logic                bank_last;
  logic                entry_last;
  logic [ADDR_W-1:0]   base;

  assign hs         = s_valid & s_ready;
  assign bank_last  = bank_cnt == (layer ? L2_LAST : L1_LAST);
  assign entry_last = entry_cnt == E_LAST;
  assign base       = layer ? BASE2 : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      layer     <= 1'b0;
      bank_cnt  <= '0;
      entry_cnt <= '0;
      s_ready   <= 1'b0;
      wr_en     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      wr_en     <= '0;
      load_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (load_start) begin
            state     <= S_LOAD;
            layer     <= nth_conv_i;
            bank_cnt  <= '0;
            entry_cnt <= '0;
            s_ready   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (hs) begin
            wr_en   <= bank_onehot(bank_cnt);
            wr_addr <= base + ADDR_W'(entry_cnt);
            wr_data <= s_data;
            if (bank_last) begin
              bank_cnt <= '0;
              if (entry_last) begin
                // final write and done pulse land together
                state     <= S_DONE;
                s_ready   <= 1'b0;
                load_done <= 1'b1;
              end else begin
                entry_cnt <= entry_cnt + 1'b1;
              end
            end else begin
              bank_cnt <= bank_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          entry_cnt <= '0;
        end
        default: begin
          state   <= S_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Weight loader bench: fixed vector table, then
// byte-count model driven loads with random stalls.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        nth_conv_i;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [15:0] wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        load_done;

  int checks = 0;
  int errors = 0;

  weight_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .nth_conv_i (nth_conv_i),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        nc;
    logic        sv;
    logic [7:0]  sd;
    logic        rn;
    logic [15:0] en;
    logic [5:0]  addr;
    logic [7:0]  data;
    logic        rdy;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t vt[9];

  // Model: load progress as a plain byte count
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_layer  = 0;
  int          m_n      = 0;
  logic [15:0] e_en     = '0;
  logic [5:0]  e_addr   = '0;
  logic [7:0]  e_data   = '0;

  int          wcount;
  int          hicount;
  int          dcount;
  logic [5:0]  last_addr;
  logic [15:0] last_en;

  task automatic cycle(input logic st, input logic nc,
                       input logic sv, input logic [7:0] sd,
                       input logic rn);
    int nb;
    load_start = st;
    nth_conv_i = nc;
    s_valid    = sv;
    s_data     = sd;
    rst_n      = rn;
    e_en = '0;
    if (!rn) begin
      m_active = 0;
      m_done   = 0;
      e_addr   = '0;
      e_data   = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (sv) begin
        nb     = m_layer ? 16 : 6;
        e_en   = 16'(1) << (m_n % nb);
        e_addr = 6'((m_layer ? 25 : 0) + m_n / nb);
        e_data = sd;
        m_n++;
        if (m_n == nb * 25) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (st) begin
      m_active = 1;
      m_layer  = nc;
      m_n      = 0;
    end
    @(posedge clk);
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_active));
    chk("busy", 32'(busy), 32'(m_active | m_done));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("wr_en", 32'(wr_en), 32'(e_en));
    chk("wr_addr", 32'(wr_addr), 32'(e_addr));
    chk("wr_data", 32'(wr_data), 32'(e_data));
    if (wr_en != 0) begin
      wcount++;
      last_addr = wr_addr;
      last_en   = wr_en;
    end
    if (!m_layer && wr_en[15:6] != 0) hicount++;
    if (load_done) dcount++;
  endtask

  task automatic clr_stats();
    wcount    = 0;
    hicount   = 0;
    dcount    = 0;
    last_addr = '0;
    last_en   = '0;
  endtask

  task automatic run_load(input logic nc, input int pct,
                          input bit spur);
    int guard = 0;
    clr_stats();
    cycle(1'b1, nc, 1'b0, 8'h00, 1'b1);
    while ((m_active || m_done) && guard < 3000) begin
      cycle(spur && ($urandom_range(0, 7) == 0),
            1'($urandom), $urandom_range(1, 100) <= pct,
            8'($urandom), 1'b1);
      guard++;
    end
    if (guard >= 3000) begin
      errors++;
      $display("FAIL load_timeout: got %0d cycles", guard);
    end
    chk("writes", 32'(wcount), nc ? 32'd400 : 32'd150);
    chk("done_pulses", 32'(dcount), 32'd1);
    chk("last_addr", 32'(last_addr), nc ? 32'd49 : 32'd24);
    chk("last_bank", 32'(last_en),
        nc ? 32'h8000 : 32'h0020);
    if (!nc) chk("hi_bank_writes", 32'(hicount), 32'd0);
  endtask

  initial begin
    //        st  nc  sv  sd     rn  en       addr data   r  b  d
    vt[0] = '{0, 0, 0, 8'h00, 0, 16'h0000, 0,  8'h00, 0, 0, 0};
    vt[1] = '{0, 0, 1, 8'hAA, 1, 16'h0000, 0,  8'h00, 0, 0, 0};
    vt[2] = '{1, 1, 1, 8'hBB, 1, 16'h0000, 0,  8'h00, 1, 1, 0};
    vt[3] = '{0, 0, 1, 8'h11, 1, 16'h0001, 25, 8'h11, 1, 1, 0};
    vt[4] = '{1, 0, 1, 8'h22, 1, 16'h0002, 25, 8'h22, 1, 1, 0};
    vt[5] = '{0, 0, 0, 8'h33, 1, 16'h0000, 25, 8'h22, 1, 1, 0};
    vt[6] = '{0, 1, 1, 8'h44, 1, 16'h0004, 25, 8'h44, 1, 1, 0};
    vt[7] = '{0, 0, 1, 8'h55, 0, 16'h0000, 0,  8'h00, 0, 0, 0};
    vt[8] = '{0, 0, 1, 8'h66, 1, 16'h0000, 0,  8'h00, 0, 0, 0};

    for (int i = 0; i < 9; i++) begin
      load_start = vt[i].st;
      nth_conv_i = vt[i].nc;
      s_valid    = vt[i].sv;
      s_data     = vt[i].sd;
      rst_n      = vt[i].rn;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vt[i].en));
      chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr),
          32'(vt[i].addr));
      chk($sformatf("vec%0d_wr_data", i), 32'(wr_data),
          32'(vt[i].data));
      chk($sformatf("vec%0d_s_ready", i), 32'(s_ready),
          32'(vt[i].rdy));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      chk($sformatf("vec%0d_load_done", i), 32'(load_done),
          32'(vt[i].dn));
    end

    // idle with valid asserted and no start
    clr_stats();
    repeat (100) cycle(1'b0, 1'($urandom), 1'b1, 8'($urandom), 1'b1);
    chk("idle_writes", 32'(wcount), 32'd0);

    run_load(1'b0, 100, 1'b0);
    run_load(1'b1, 100, 1'b0);
    run_load(1'b1, 50, 1'b0);
    run_load(1'b1, 100, 1'b1);

    // reset after 70 bytes of a layer 2 load
    clr_stats();
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int g = 0; g < 1000 && m_n < 70; g++)
      cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
    chk("bytes_before_reset", 32'(wcount), 32'd70);
    cycle(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h5B, 1'b1);
    chk("abandoned_done", 32'(dcount), 32'd0);
    run_load(1'b0, 100, 1'b0);

    for (int k = 0; k < 4; k++)
      run_load(1'($urandom), $urandom_range(30, 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
